mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_sat_counter.sv | 31 +++
 rtl/mem_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_stage_pkg;

  localparam int unsigned MEM_LIMIT_DEFAULT = 511;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  tag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // True when a word address lies outside the populated dmem range.
  function automatic logic addr_faults(input word_t addr, input int unsigned limit);
    return (32'(addr) >= limit);
  endfunction

endpackage

// File: rtl/mem_stage_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: one outstanding request, single-cycle dmem access, held response.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_LIMIT = MEM_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_rd,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_rw_,
  output logic        dmem_cs,
  input  logic [15:0] dmem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_rd,
  output logic        rsp_we,
  output logic        rsp_fault,
  output logic [15:0] fault_cnt
);

  state_e state_q;
  state_e state_d;

  logic  we_q;
  word_t addr_q;
  word_t wdata_q;
  tag_t  rd_q;
  logic  fault_q;
  word_t rsp_data_q;

  logic accept;
  logic req_fault;

  assign req_fault = addr_faults(req_addr, MEM_LIMIT);

  // dmem strobes depend on state_q only, so no req_* input reaches them.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    dmem_cs   = 1'b0;
    dmem_rw_  = 1'b1;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) begin
          if (req_fault) begin
            state_d = ST_RESP;
          end else if (req_we) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        dmem_cs = 1'b1;
        state_d = ST_RESP;
      end
      ST_WRITE: begin
        dmem_cs  = 1'b1;
        dmem_rw_ = 1'b0;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      fault_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= req_we;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rd_q       <= req_rd;
        fault_q    <= req_fault;
        rsp_data_q <= '0;
      end else if (state_q == ST_READ) begin
        // Only sampled while selected, so a floating bus never leaks out.
        rsp_data_q <= dmem_rdata;
      end
    end
  end

  sat_counter #(
    .WIDTH(16)
  ) u_fault_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (accept && req_fault),
    .count(fault_cnt)
  );

  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_rd     = rd_q;
  assign rsp_we     = we_q;
  assign rsp_fault  = fault_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl with an attached dmem model.
module tb_mem_stage_ctrl;

  localparam int LIMIT = 511;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [2:0]  req_rd;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_rw_;
  logic        dmem_cs;
  logic [15:0] dmem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_we;
  logic        rsp_fault;
  logic [15:0] fault_cnt;

  logic rdy_fixed;
  logic rdy_rand;
  bit   rand_ready_en = 1'b0;

  assign rsp_ready = rand_ready_en ? rdy_rand : rdy_fixed;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.MEM_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rw_  (dmem_rw_),
    .dmem_cs   (dmem_cs),
    .dmem_rdata(dmem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_rd    (rsp_rd),
    .rsp_we    (rsp_we),
    .rsp_fault (rsp_fault),
    .fault_cnt (fault_cnt)
  );

  // dmem model: combinational read, write on the clock edge; garbage when deselected.
  logic [15:0] mem [0:511];
  assign dmem_rdata = dmem_cs ? mem[dmem_addr[8:0]] : 16'hDEAD;
  always @(posedge clk) begin
    if (dmem_cs && !dmem_rw_) mem[dmem_addr[8:0]] <= dmem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        we;
    logic        fault;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [0:511];
  int          fcnt_model = 0;
  int          checks = 0;
  int          failures = 0;
  int          cs_cnt = 0;
  int          resp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples after the driver has settled its inputs for the cycle.
  initial begin
    bit   cont = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (dmem_cs) begin
        cs_cnt++;
        chk("cs_addr_in_range", 32'(dmem_addr < 16'(LIMIT)), 1);
      end
      if (rsp_valid) begin
        chk("req_ready_low_in_resp", 32'(req_ready), 0);
        chk("cs_low_in_resp", 32'(dmem_cs), 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_response actual=rsp_valid required=none t=%0t", $time);
        end else begin
          e = exp_q[0];
          if (!cont) chk("latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
          chk("rsp_we", 32'(rsp_we), 32'(e.we));
          chk("rsp_fault", 32'(rsp_fault), 32'(e.fault));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            resp_cnt++;
          end
        end
      end
      cont = rsp_valid && !rsp_ready;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [2:0] rd, input bit hold);
    exp_t e;
    bit   done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      req_rd    = rd;
      #1;
      if (req_ready && rst_n) begin
        done    = 1'b1;
        e.fault = (int'(addr) >= LIMIT);
        e.we    = we;
        e.rd    = rd;
        e.acc   = cyc + 1;
        e.lat   = e.fault ? 1 : 2;
        e.data  = (e.fault || we) ? 16'h0 : ref_mem[addr[8:0]];
        if (!e.fault && we) ref_mem[addr[8:0]] = wd;
        if (e.fault && fcnt_model != 16'hFFFF) fcnt_model++;
        exp_q.push_back(e);
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 80; n++) begin
      if (exp_q.size() == 0 && !rsp_valid) break;
      @(negedge clk);
      #2;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic check_fcnt(input string name);
    @(negedge clk);
    #2;
    chk(name, 32'(fault_cnt), 32'(fcnt_model));
  endtask

  initial begin
    int c0;
    int r0;
    bit seen;
    logic [15:0] a;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'hFFFF;
    req_wdata = 16'h0;
    req_rd    = 3'd0;
    rdy_fixed = 1'b1;

    // Request held during reset must not be accepted.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("req_ready_in_reset", 32'(req_ready), 1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_dmem_cs", 32'(dmem_cs), 0);
    chk("rst_dmem_rw", 32'(dmem_rw_), 1);
    chk("rst_dmem_addr", 32'(dmem_addr), 0);
    chk("rst_dmem_wdata", 32'(dmem_wdata), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_rd", 32'(rsp_rd), 0);
    chk("rst_rsp_we", 32'(rsp_we), 0);
    chk("rst_rsp_fault", 32'(rsp_fault), 0);
    chk("rst_fault_cnt", 32'(fault_cnt), 0);

    // Populate the addresses the random phase will read.
    for (int i = 0; i < 16; i++) issue(1'b1, 16'(i), 16'($urandom), 3'(i), 1'b0);
    issue(1'b1, 16'd510, 16'hA510, 3'd7, 1'b0);
    drain();

    issue(1'b1, 16'd5, 16'hBEEF, 3'd0, 1'b0);
    issue(1'b0, 16'd5, 16'h0, 3'd3, 1'b0);
    drain();

    c0 = cs_cnt;
    issue(1'b0, 16'd510, 16'h0, 3'd1, 1'b0);
    drain();
    chk("load510_cs_cycles", 32'(cs_cnt - c0), 1);
    c0 = cs_cnt;
    issue(1'b0, 16'd511, 16'h0, 3'd2, 1'b0);
    drain();
    chk("fault511_no_cs", 32'(cs_cnt - c0), 0);
    check_fcnt("fault_cnt_one");

    issue(1'b1, 16'd9, 16'h1234, 3'd2, 1'b0);
    drain();
    r0 = resp_cnt;
    rdy_fixed = 1'b0;
    issue(1'b0, 16'd9, 16'h0, 3'd4, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      #2;
      seen = rsp_valid;
    end
    chk("stall_rsp_seen", 32'(seen), 1);
    repeat (4) @(negedge clk);
    chk("stall_no_early_resp", 32'(resp_cnt - r0), 0);
    rdy_fixed = 1'b1;
    drain();
    chk("stall_one_resp", 32'(resp_cnt - r0), 1);

    // Reset lands on the WRITE cycle: write commits, response is dropped.
    r0 = resp_cnt;
    issue(1'b1, 16'd7, 16'h00AA, 3'd5, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    fcnt_model = 0;
    #1;
    chk("write_cycle_cs", 32'(dmem_cs), 1);
    chk("write_cycle_rw", 32'(dmem_rw_), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 32'(req_ready), 1);
    repeat (3) @(negedge clk);
    chk("post_rst_no_resp", 32'(resp_cnt - r0), 0);
    issue(1'b0, 16'd7, 16'h0, 3'd6, 1'b0);
    drain();

    c0 = cs_cnt;
    r0 = resp_cnt;
    issue(1'b0, 16'd3, 16'h0, 3'd1, 1'b1);
    issue(1'b1, 16'd4, 16'h5555, 3'd2, 1'b1);
    issue(1'b0, 16'd600, 16'h0, 3'd3, 1'b1);
    issue(1'b0, 16'd4, 16'h0, 3'd4, 1'b0);
    drain();
    chk("b2b_cs_cycles", 32'(cs_cnt - c0), 3);
    chk("b2b_responses", 32'(resp_cnt - r0), 4);
    check_fcnt("b2b_fault_cnt");

    rand_ready_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 16'd510;
        1:       a = 16'd511;
        2:       a = 16'($urandom_range(511, 65535));
        default: a = 16'($urandom_range(0, 15));
      endcase
      issue(1'($urandom_range(0, 1)), a, 16'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    req_valid = 1'b0;
    rand_ready_en = 1'b0;
    drain();
    check_fcnt("random_fault_cnt");

    @(negedge clk);
    force dut.u_fault_cnt.count_q = 16'hFFFE;
    @(negedge clk);
    release dut.u_fault_cnt.count_q;
    fcnt_model = 16'hFFFE;
    check_fcnt("fault_cnt_forced");
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 16'hFFFF, 16'h0, 3'(i), 1'b0);
      drain();
      check_fcnt("fault_cnt_saturate");
    end

    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
